// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- RV32I load/store unit controller.
//
// Accepts one core access at a time, checks width/alignment legality, issues a
// single word-aligned bus request with byte strobes and lane-replicated store
// data, waits (with timeout) for the bus, and returns a one-cycle completion
// pulse carrying either extended load data or a fault flag.
//
// Ports:
//   clk, reset_n            single clock, synchronous active-low reset
//   req_valid/req_ready     core handshake; req_ready is high only when idle
//   req_write, req_funct3   access kind (1 = store) and RV32I width/sign code
//   req_addr, req_wdata     byte address and right-aligned store data
//   resp_valid/resp_err     one-cycle completion pulse and fault flag
//   resp_rdata              extended load data (0 for stores and faults)
//   mem_valid/mem_ready     bus request / bus accept-complete
//   mem_we, mem_addr        bus write enable and word address
//   mem_wstrb, mem_wdata    byte lane enables and replicated store data
//   mem_rdata               bus read word, valid while mem_ready is high
module lsu_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  localparam logic [8:0] WAIT_LIMIT = 9'(MAX_WAIT);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic        lat_write;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rd_word;
  logic        accept;
  logic        in_issue;
  logic        timeout;

  function automatic logic is_legal(input logic wr, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (wr) begin
      case (f3)
        3'b000:  ok = 1'b1;
        3'b001:  ok = ~a[0];
        3'b010:  ok = (a == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: ok = 1'b1;
        3'b001, 3'b101: ok = ~a[0];
        3'b010:         ok = (a == 2'b00);
        default:        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Only legal store codes reach ISSUE, so funct3[1:0] alone selects the width.
  function automatic logic [3:0] strb_of(input logic [1:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3)
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lanes_of(input logic [1:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // The word is already shifted down so the addressed byte/half sits at bit 0.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [31:0]        r;
    sb = w[7:0];
    sh = w[15:0];
    case (f3)
      3'b000:  r = 32'(sb);
      3'b100:  r = {24'd0, w[7:0]};
      3'b001:  r = 32'(sh);
      3'b101:  r = {16'd0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept   = (state == IDLE) && req_valid;
  assign in_issue = (state == ISSUE);
  assign timeout  = ({1'b0, wait_cnt} + 9'd1) == WAIT_LIMIT;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state    <= is_legal(req_write, req_funct3, req_addr[1:0]) ? ISSUE : ERR;
            wait_cnt <= 8'd0;
          end
        end
        ISSUE: begin
          // A ready on the final permitted cycle still wins over the timeout.
          if (mem_ready) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout) state <= ERR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Access capture and read-word capture; outputs gate these by state, so
  // they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write  <= req_write;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end
    if (in_issue && mem_ready) begin
      rd_word <= mem_rdata >> {lat_addr[1:0], 3'b000};
    end
  end

  assign req_ready  = (state == IDLE);
  assign mem_valid  = in_issue;
  assign mem_we     = in_issue && lat_write;
  assign mem_addr   = in_issue ? {lat_addr[31:2], 2'b00} : 32'd0;
  assign mem_wstrb  = mem_we ? strb_of(lat_funct3[1:0], lat_addr[1:0]) : 4'b0000;
  assign mem_wdata  = mem_we ? lanes_of(lat_funct3[1:0], lat_wdata) : 32'd0;
  assign resp_valid = (state == RESP) || (state == ERR);
  assign resp_err   = (state == ERR);
  assign resp_rdata = ((state == RESP) && !lat_write) ? extend(lat_funct3, rd_word) : 32'd0;

endmodule
